// File: rtl/freq_mult_datapath.sv
// ----------------------------------------------------------------------------
// FreqMultDP -- datapath of the digital frequency multiplier.
//
// Measures the period of the slow InFreq input in RefClk cycles and
// regenerates it as OutFreq, a square wave running at 2^n times the input
// frequency. The output half-period is exported as shiftduration. A separate
// controller uses init to restart the measurement.
//
// Ports
//   RefClk         in   1      reference clock, all logic on its rising edge
//   rst            in   1      asynchronous reset, active low
//   InFreq         in   1      slow input, asynchronous to RefClk
//   init           in   1      synchronous clear/restart, active high
//   n              in   3      multiplication exponent (OutFreq = InFreq*2^n)
//   OutFreq        out  1      multiplied square wave
//   shiftduration  out  CNT_W  output half-period = period >> (n+1)
// ----------------------------------------------------------------------------
module freq_mult_datapath #(
  parameter int CNT_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             InFreq,
  input  logic             init,
  input  logic [2:0]       n,
  output logic             OutFreq,
  output logic [CNT_W-1:0] shiftduration
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                prev_q, prev_d;
  logic [CNT_W-1:0]    pc_q, pc_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    sd_q, sd_d;
  logic [CNT_W-1:0]    oc_q, oc_d;
  logic                out_q, out_d;

  logic                rise;
  logic [CNT_W-1:0]    pcNext;
  logic [3:0]          shiftAmt;

  // Rising edge of the synchronised input, one cycle wide.
  assign rise = sync_q[SYNC_STG-1] & ~prev_q;

  // Saturating increment; it doubles as the captured period (pc+1), so a
  // stuck input reports the maximum count instead of wrapping to a tiny value.
  assign pcNext = (pc_q == CNT_MAX) ? CNT_MAX : (pc_q + CNT_ONE);

  // Half-period of the output is period / 2^(n+1); n+1 needs four bits.
  assign shiftAmt = {1'b0, n} + 4'd1;

  always_comb begin
    sync_d  = {sync_q[SYNC_STG-2:0], InFreq};
    prev_d  = sync_q[SYNC_STG-1];
    pc_d    = rise ? '0 : pcNext;
    armed_d = armed_q | rise;
    sd_d    = sd_q;
    oc_d    = oc_q;
    out_d   = out_q;

    // The first edge after a clear only starts the measurement window.
    if (rise && armed_q) begin
      sd_d = pcNext >> shiftAmt;
    end

    // Greater-or-equal compare: if shiftduration shrinks below the running
    // count the output still toggles on the next edge instead of wrapping.
    if (sd_q == '0) begin
      oc_d  = '0;
      out_d = 1'b0;
    end else if (oc_q >= (sd_q - CNT_ONE)) begin
      oc_d  = '0;
      out_d = ~out_q;
    end else begin
      oc_d  = oc_q + CNT_ONE;
    end

    // Restart overrides everything, including an edge seen in this cycle.
    if (init) begin
      sync_d  = '0;
      prev_d  = 1'b0;
      pc_d    = '0;
      armed_d = 1'b0;
      sd_d    = '0;
      oc_d    = '0;
      out_d   = 1'b0;
    end
  end

  always_ff @(posedge RefClk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pc_q    <= '0;
      armed_q <= 1'b0;
      sd_q    <= '0;
      oc_q    <= '0;
      out_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pc_q    <= pc_d;
      armed_q <= armed_d;
      sd_q    <= sd_d;
      oc_q    <= oc_d;
      out_q   <= out_d;
    end
  end

  assign OutFreq       = out_q;
  assign shiftduration = sd_q;

endmodule

// File: tb/tb_freq_mult_datapath.sv
// ----------------------------------------------------------------------------
// Testbench for freq_mult_datapath. Drives InFreq as a square wave of chosen
// period, predicts shiftduration from the cycle distance between input rises,
// and checks the spacing of OutFreq toggles against the predicted half-period.
// ----------------------------------------------------------------------------
module tb_freq_mult_datapath;

  logic        RefClk = 1'b0;
  logic        rst;
  logic        InFreq;
  logic        init;
  logic [2:0]  n;
  logic        OutFreq;
  logic [15:0] shiftduration;

  freq_mult_datapath #(.CNT_W(16), .SYNC_STG(2)) dut (
    .RefClk        (RefClk),
    .rst           (rst),
    .InFreq        (InFreq),
    .init          (init),
    .n             (n),
    .OutFreq       (OutFreq),
    .shiftduration (shiftduration)
  );

  always #5 RefClk = ~RefClk;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;
  int   expSd       = 0;
  bit   armedModel  = 1'b0;
  int   lastRiseCyc = 0;
  int   sdChangeCyc = 0;
  int   lastToggleCyc = 0;
  logic lastOut     = 1'b0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Behavioural model: a clear forgets the measurement entirely.
  task automatic modelClear();
    expSd         = 0;
    armedModel    = 1'b0;
    sdChangeCyc   = cyc;
    lastToggleCyc = cyc;
    lastOut       = 1'b0;
  endtask

  // One clock, sampled 1 time unit after the edge; also watches OutFreq.
  task automatic tick(input bit clearEdge = 1'b0);
    @(posedge RefClk);
    #1;
    cyc++;
    if (clearEdge) modelClear();
    if (OutFreq !== lastOut) begin
      // Gap is only predictable if the half-period held since the last toggle.
      if (expSd != 0 && lastToggleCyc >= sdChangeCyc)
        checkOutput("toggleGap", cyc - lastToggleCyc, expSd);
      lastToggleCyc = cyc;
      lastOut       = OutFreq;
    end else if (expSd != 0 && (cyc - lastToggleCyc) > expSd + 1 &&
                 (cyc - sdChangeCyc) > expSd + 1) begin
      checkOutput("outStall", cyc - lastToggleCyc, expSd);
      lastToggleCyc = cyc;
    end
  endtask

  // Drives `rises` full periods of InFreq, each `period` cycles long (>= 6).
  task automatic applyStimulus(input int period, input int rises);
    int riseCyc;
    int p;
    int newSd;
    int half;
    half = period / 2;
    for (int r = 0; r < rises; r++) begin
      InFreq  = 1'b1;
      riseCyc = cyc;
      repeat (3) tick();
      if (armedModel) begin
        p = riseCyc - lastRiseCyc;
        if (p > 65535) p = 65535;
        newSd = p >> (int'(n) + 1);
        if (newSd != expSd) begin
          expSd       = newSd;
          sdChangeCyc = cyc;
        end
      end
      checkOutput("shiftduration", int'(shiftduration), expSd);
      armedModel  = 1'b1;
      lastRiseCyc = riseCyc;
      repeat (half - 3) tick();
      InFreq = 1'b0;
      repeat (period - half) tick();
      if (expSd == 0) checkOutput("outIdle", int'(OutFreq), 0);
    end
  endtask

  task automatic applyInit();
    init = 1'b1;
    tick(1'b1);
    init = 1'b0;
    checkOutput("initSd", int'(shiftduration), 0);
    checkOutput("initOut", int'(OutFreq), 0);
  endtask

  initial begin
    rst    = 1'b0;
    init   = 1'b0;
    InFreq = 1'b0;
    n      = 3'd0;
    modelClear();
    repeat (5) tick(1'b1);
    checkOutput("resetSd", int'(shiftduration), 0);
    checkOutput("resetOut", int'(OutFreq), 0);
    rst = 1'b1;

    // Static input: nothing must appear.
    repeat (50) tick();
    checkOutput("idleSd", int'(shiftduration), 0);
    checkOutput("idleOut", int'(OutFreq), 0);

    // 3000-cycle input, n=3: first rise arms only, second gives 187.
    n = 3'd3;
    applyStimulus(3000, 2);

    // Same input, n=0 then n=7.
    n = 3'd0;
    applyStimulus(3000, 1);
    n = 3'd7;
    applyStimulus(3000, 1);

    // Short period collapses the half-period to zero.
    n = 3'd3;
    applyStimulus(10, 3);

    // Randomised periods and exponents, with a restart in the middle.
    for (int k = 0; k < 5; k++) begin
      n = 3'($urandom_range(0, 7));
      applyStimulus(int'($urandom_range(6, 300)), 3);
      if (k == 2) begin
        applyInit();
        n = 3'($urandom_range(0, 3));
        applyStimulus(int'($urandom_range(40, 300)), 1);
        checkOutput("rearmSd", int'(shiftduration), 0);
        applyStimulus(int'($urandom_range(40, 300)), 2);
      end
    end

    // Period beyond the counter range saturates at 0xFFFF.
    n = 3'd3;
    applyStimulus(65600, 1);
    applyStimulus(40, 2);

    // Asynchronous reset while the output is high.
    for (int w = 0; w < 200 && OutFreq !== 1'b1; w++) tick();
    checkOutput("preResetOut", int'(OutFreq), 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncSd", int'(shiftduration), 0);
    checkOutput("asyncOut", int'(OutFreq), 0);
    modelClear();
    repeat (3) tick(1'b1);
    rst = 1'b1;
    repeat (20) tick();
    checkOutput("postResetSd", int'(shiftduration), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
